// File: rtl/hazard3_ahbl_sram_if.sv
// AHB-Lite slave bus bundle for hazard3_ahbl_sram.
// hready is the bus-level ready; hready_resp is this slave's response.
interface hazard3_ahbl_sram_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hready;
    logic              hready_resp;
    logic              hresp;
    logic              hexcl;
    logic              hexokay;
    logic [W_DATA-1:0] hwdata;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output haddr, hwrite, htrans, hsize, hready, hexcl, hwdata,
        input  hready_resp, hresp, hexokay, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hready, hexcl, hwdata,
        output hready_resp, hresp, hexokay, hrdata
    );
endinterface

// File: rtl/hazard3_ahbl_sram.sv
// AHB-Lite to synchronous SRAM bridge with a one-entry write buffer.
// Define HAZARD3_AHBL_SRAM_EXCL_EN to add a single-reservation exclusive monitor.
module hazard3_ahbl_sram #(
    parameter int  W_DATA = 32,
    parameter int  W_ADDR = 32,
    parameter int  DEPTH  = 4096,
    localparam int W_IDX  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard3_ahbl_sram_if.slave ahbl,
    output logic [W_IDX-1:0]   sram_addr,
    output logic               sram_ce,
    output logic               sram_we,
    output logic [3:0]         sram_be,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    typedef enum logic [1:0] {ERR_IDLE, ERR_FIRST, ERR_SECOND} err_state_t;

    logic [W_ADDR-1:0] haddr;
    logic [W_IDX-1:0]  aph_idx;
    logic [3:0]        aph_lanes;
    logic              aph_misalign, aph_err;
    logic              rd_req, rd_acc, wr_acc, err_acc;

    logic              dph_read, dph_write;
    logic [W_IDX-1:0]  dph_idx;
    logic [3:0]        dph_lanes;

    logic              buf_valid;
    logic [W_IDX-1:0]  buf_idx;
    logic [3:0]        buf_be;
    logic [W_DATA-1:0] buf_data;
    logic              buf_hit, stall, commit, wr_cap, wr_ok;

    err_state_t        err_state;
    logic              err_ready, err_resp;
    logic [W_DATA-1:0] rdata;
    logic              unused_ok;

    assign haddr   = ahbl.haddr;
    assign aph_idx = haddr[W_IDX+1:2];

    always_comb begin
        aph_lanes    = 4'hf;
        aph_misalign = 1'b0;
        case (ahbl.hsize)
            3'd0: aph_lanes = 4'b0001 << haddr[1:0];
            3'd1: begin
                aph_lanes    = haddr[1] ? 4'b1100 : 4'b0011;
                aph_misalign = haddr[0];
            end
            3'd2:    aph_misalign = |haddr[1:0];
            default: ;
        endcase
    end

    assign aph_err = ((haddr >> (W_IDX + 2)) != '0) || (ahbl.hsize > 3'd2) || aph_misalign;
    // rd_req ignores hready so the stall decision never loops back through the bus ready
    assign rd_req  = ahbl.htrans[1] && !ahbl.hwrite && !aph_err;
    assign rd_acc  = ahbl.hready && rd_req;
    assign wr_acc  = ahbl.hready && ahbl.htrans[1] && ahbl.hwrite && !aph_err;
    assign err_acc = ahbl.hready && ahbl.htrans[1] && aph_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_read  <= 1'b0;
            dph_write <= 1'b0;
            dph_idx   <= '0;
            dph_lanes <= '0;
        end else if (ahbl.hready) begin
            dph_read  <= rd_acc;
            dph_write <= wr_acc;
            dph_idx   <= aph_idx;
            dph_lanes <= aph_lanes;
        end
    end

`ifdef HAZARD3_AHBL_SRAM_EXCL_EN
    logic dph_excl, resv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_excl <= 1'b0;
            resv     <= 1'b0;
        end else begin
            if (ahbl.hready)
                dph_excl <= ahbl.hexcl;
            if (dph_write && !stall)
                resv <= 1'b0;
            else if (dph_read && dph_excl)
                resv <= 1'b1;
        end
    end

    assign wr_ok        = !dph_excl || resv;
    assign ahbl.hexokay = dph_excl && (dph_read || (dph_write && resv));
    assign unused_ok    = ahbl.htrans[0];
`else
    assign wr_ok        = 1'b1;
    assign ahbl.hexokay = 1'b0;
    assign unused_ok    = ^{ahbl.htrans[0], ahbl.hexcl};
`endif

    // A read address phase owns the SRAM port; the buffer drains on any other cycle
    assign stall  = dph_write && buf_valid && rd_req;
    assign commit = buf_valid && !rd_acc;
    assign wr_cap = dph_write && !stall && wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_be    <= '0;
            buf_data  <= '0;
        end else if (wr_cap) begin
            buf_valid <= 1'b1;
            buf_idx   <= dph_idx;
            buf_be    <= dph_lanes;
            buf_data  <= ahbl.hwdata;
        end else if (commit) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_state <= ERR_IDLE;
            err_ready <= 1'b1;
            err_resp  <= 1'b0;
        end else begin
            case (err_state)
                ERR_FIRST: begin
                    err_state <= ERR_SECOND;
                    err_ready <= 1'b1;
                    err_resp  <= 1'b1;
                end
                default: begin
                    if (err_acc) begin
                        err_state <= ERR_FIRST;
                        err_ready <= 1'b0;
                        err_resp  <= 1'b1;
                    end else begin
                        err_state <= ERR_IDLE;
                        err_ready <= 1'b1;
                        err_resp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ahbl.hready_resp = err_ready && !stall;
    assign ahbl.hresp       = err_resp;

    assign sram_ce    = rd_acc || commit;
    assign sram_we    = commit;
    assign sram_addr  = rd_acc ? aph_idx : buf_idx;
    assign sram_be    = commit ? buf_be : 4'h0;
    assign sram_wdata = buf_data;

    // Buffered lanes are newer than the SRAM copy
    assign buf_hit = buf_valid && (buf_idx == dph_idx);

    always_comb begin
        rdata = sram_rdata;
        for (int b = 0; b < 4; b++)
            if (buf_hit && buf_be[b])
                rdata[8*b +: 8] = buf_data[8*b +: 8];
    end

    assign ahbl.hrdata = rdata;

endmodule

// File: tb/tb_hazard3_ahbl_sram.sv
// Scoreboard bench for hazard3_ahbl_sram: driver pushes expected responses,
// a negedge monitor pops and compares on each completed data phase.
module tb_hazard3_ahbl_sram;
    localparam int DEPTH = 4096;
`ifdef HAZARD3_AHBL_SRAM_EXCL_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard3_ahbl_sram_if #(.W_ADDR(32), .W_DATA(32)) bus ();
    assign bus.hready = bus.hready_resp;

    logic [11:0] sram_addr;
    logic        sram_ce, sram_we;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata, sram_rdata;

    hazard3_ahbl_sram #(.W_DATA(32), .W_ADDR(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ahbl(bus),
        .sram_addr(sram_addr), .sram_ce(sram_ce), .sram_we(sram_we),
        .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    bit [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] rdata;
        bit          exok;
        int          waits;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, xid = 0;
    int   ce_cnt = 0, we_cnt = 0;
    bit   mon_off = 1'b0;
    bit   mon_in_dph = 1'b0, mon_wresp = 1'b0;
    int   mon_nwait = 0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sram_ce) ce_cnt++;
            if (sram_ce && sram_we) we_cnt++;
            if (!rst_n || mon_off) begin
                mon_in_dph = 1'b0;
                mon_nwait  = 0;
                mon_wresp  = 1'b0;
            end else begin
                if (mon_in_dph) begin
                    if (bus.hready_resp) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sb_underflow got=response exp=none");
                        end else begin
                            mon_e = sb.pop_front();
                            chk($sformatf("x%0d_waits", mon_e.id), 32'(mon_nwait), 32'(mon_e.waits));
                            chk($sformatf("x%0d_resp", mon_e.id), {30'b0, bus.hresp, mon_wresp},
                                {30'b0, mon_e.err, mon_e.err});
                            chk($sformatf("x%0d_exokay", mon_e.id), 32'(bus.hexokay), 32'(mon_e.exok));
                            if (!mon_e.wr && !mon_e.err)
                                chk($sformatf("x%0d_rdata", mon_e.id), bus.hrdata, mon_e.rdata);
                        end
                        mon_nwait = 0;
                        mon_wresp = 1'b0;
                    end else begin
                        mon_nwait++;
                        mon_wresp = mon_wresp | bus.hresp;
                        if (mon_nwait > 20) begin
                            checks++;
                            failures++;
                            $display("FAIL dph_timeout got=%0d waits exp<=20", mon_nwait);
                            mon_in_dph = 1'b0;
                            mon_nwait  = 0;
                        end
                    end
                end
                if (bus.hready_resp) mon_in_dph = bus.htrans[1];
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input bit excl, input logic [31:0] erd,
                         input bit eerr, input bit eexok, input int ewait);
        bit r;
        bit ok;
        ok = 1'b0;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.hexcl  = excl;
        bus.htrans = 2'b10;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            r = bus.hready_resp;
            @(posedge clk);
            ok = r;
        end
        #1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL x%0d_accept got=timeout exp=accepted", xid);
        end else begin
            sb.push_back('{wr, eerr, erd, eexok, ewait, xid});
            if (wr) bus.hwdata = wdata;
        end
        xid++;
        bus.htrans = 2'b00;
        bus.hexcl  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.htrans = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int ce0, we0;

    initial begin
        bus.haddr = '0; bus.hwrite = 1'b0; bus.htrans = 2'b00;
        bus.hsize = 3'd0; bus.hexcl = 1'b0; bus.hwdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_hready_resp", 32'(bus.hready_resp), 32'd1);
        chk("rst_hresp",       32'(bus.hresp),       32'd0);
        chk("rst_hexokay",     32'(bus.hexokay),     32'd0);
        chk("rst_sram_ce",     32'(sram_ce),         32'd0);
        chk("rst_sram_we",     32'(sram_we),         32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        // preload through the bus: second write drains the first with no wait
        issue(1, 32'h08, 3'd2, 32'h55667788, 0, 0, 0, 0, 0);
        issue(1, 32'h40, 3'd2, 32'h12345678, 0, 0, 0, 0, 0);
        idle(3);

        // byte write merges with SRAM word on read-after-write
        issue(1, 32'h13, 3'd0, 32'hAA000000, 0, 0, 0, 0, 0);
        issue(0, 32'h10, 3'd2, 0, 0, 32'hAA000000, 0, 0, 0);
        idle(3);

        // full word served from the buffer back-to-back
        issue(1, 32'h10, 3'd2, 32'h11223344, 0, 0, 0, 0, 0);
        issue(0, 32'h10, 3'd2, 0, 0, 32'h11223344, 0, 0, 0);
        idle(3);

        // halfword write then read from SRAM after drain
        issue(1, 32'h12, 3'd1, 32'hBEEF0000, 0, 0, 0, 0, 0);
        idle(3);
        issue(0, 32'h10, 3'd2, 0, 0, 32'hBEEF3344, 0, 0, 0);
        idle(3);

        // W, W, R pipelined: second write stalls one cycle
        issue(1, 32'h00, 3'd2, 32'hA0A0A0A0, 0, 0, 0, 0, 0);
        issue(1, 32'h04, 3'd2, 32'hB1B1B1B1, 0, 0, 0, 0, 1);
        issue(0, 32'h08, 3'd2, 0, 0, 32'h55667788, 0, 0, 0);
        idle(3);
        chk("mem0_after_ww", mem[0], 32'hA0A0A0A0);
        chk("mem1_after_ww", mem[1], 32'hB1B1B1B1);
        issue(0, 32'h00, 3'd2, 0, 0, 32'hA0A0A0A0, 0, 0, 0);
        issue(0, 32'h04, 3'd2, 0, 0, 32'hB1B1B1B1, 0, 0, 0);
        idle(2);

        // error transfers
        ce0 = ce_cnt;
        issue(0, 32'h4000, 3'd2, 0, 0, 0, 1, 0, 1);
        idle(3);
        chk("oob_no_sram_ce", 32'(ce_cnt - ce0), 32'd0);
        issue(1, 32'h02, 3'd2, 32'hFFFFFFFF, 0, 0, 1, 0, 1);
        issue(0, 32'h00, 3'd3, 0, 0, 0, 1, 0, 1);
        idle(3);
        issue(0, 32'h00, 3'd2, 0, 0, 32'hA0A0A0A0, 0, 0, 0);
        issue(0, 32'h03, 3'd0, 0, 0, 32'hA0A0A0A0, 0, 0, 0);
        idle(3);

        // write-write with idle address phase: old commits as new enters
        issue(1, 32'h50, 3'd2, 32'h01020304, 0, 0, 0, 0, 0);
        issue(1, 32'h54, 3'd2, 32'h05060708, 0, 0, 0, 0, 0);
        idle(3);
        issue(0, 32'h50, 3'd2, 0, 0, 32'h01020304, 0, 0, 0);
        issue(0, 32'h54, 3'd2, 0, 0, 32'h05060708, 0, 0, 0);
        idle(3);

        // exclusive sequence
        issue(0, 32'h20, 3'd2, 0, 1, 32'h0, 0, EXCL, 0);
        issue(1, 32'h20, 3'd2, 32'h5, 1, 0, 0, EXCL, 0);
        issue(1, 32'h20, 3'd2, 32'h6, 1, 0, 0, 0, 0);
        idle(3);
        issue(0, 32'h20, 3'd2, 0, 0, EXCL ? 32'h5 : 32'h6, 0, 0, 0);
        idle(3);
        chk("mem8_excl", mem[8], EXCL ? 32'h5 : 32'h6);

        // reset with a pending buffered write held off by back-to-back reads
        we0 = we_cnt;
        mon_off = 1'b1;
        bus.haddr = 32'h40; bus.hwrite = 1'b1; bus.hsize = 3'd2; bus.htrans = 2'b10;
        @(posedge clk); #1;
        bus.haddr = 32'h80; bus.hwrite = 1'b0; bus.hwdata = 32'h0000DEAD;
        @(posedge clk); #1;
        bus.haddr = 32'h84;
        #2 rst_n = 1'b0;
        bus.htrans = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst2_sram_we",     32'(sram_we),         32'd0);
        chk("rst2_sram_ce",     32'(sram_ce),         32'd0);
        chk("rst2_hready_resp", 32'(bus.hready_resp), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        mon_off = 1'b0;
        idle(2);
        issue(0, 32'h40, 3'd2, 0, 0, 32'h12345678, 0, 0, 0);
        idle(4);
        chk("rst2_no_commit", 32'(we_cnt - we0), 32'd0);
        chk("mem16_after_rst", mem[16], 32'h12345678);

        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
